// File: rtl/vig_pkg.sv
// Shared constants and helpers for the Vigenere keystream cipher blocks.
package vig_pkg;

    // ASCII bounds of the alphabet handled by the cipher.
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    localparam int unsigned ALPHA_LEN = 26;

    // Default keystream state; must never be zero or the LFSR locks up.
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    // Feedback taps for x^32 + x^22 + x^2 + x + 1 (state bits 31, 21, 1, 0).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // True when the byte is an uppercase ASCII letter.
    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z);
    endfunction

    // Reduce the 5-bit key field of the keystream into 0..25.
    function automatic logic [4:0] key_of(input logic [4:0] field);
        logic [4:0] k;
        k = field;
        if (k >= 5'(ALPHA_LEN)) begin
            k = k - 5'(ALPHA_LEN);
        end
        return k;
    endfunction

    // One Galois-free Fibonacci step: shift left, feedback into bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] ks);
        logic fb;
        fb = ^(ks & LFSR_TAPS);
        return {ks[30:0], fb};
    endfunction

    // Shift an uppercase letter back by k and return it in lowercase.
    // Adding ALPHA_LEN before subtracting keeps the 9-bit sum non-negative.
    function automatic logic [7:0] decipher(input logic [7:0] c, input logic [4:0] k);
        logic [8:0] idx;
        logic [8:0] sum;
        idx = {1'b0, c} - {1'b0, ASCII_UPPER_A};
        sum = idx + 9'(ALPHA_LEN) - {4'b0000, k};
        if (sum >= 9'(ALPHA_LEN)) begin
            sum = sum - 9'(ALPHA_LEN);
        end
        return 8'(sum + {1'b0, ASCII_LOWER_A});
    endfunction

endpackage

// File: rtl/vig_keystream.sv
// 32-bit LFSR keystream register. Reset and load take priority over a step,
// so a cipher stage can reseed it without racing its own traffic.
module vig_keystream
    import vig_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] ks
);

    logic [31:0] ks_q;
    logic [31:0] ks_d;

    // Next state: load (a zero seed falls back to SEED) beats a step.
    always_comb begin
        ks_d = ks_q;
        if (load) begin
            ks_d = (seed == 32'h0) ? SEED : seed;
        end else if (step) begin
            ks_d = lfsr_next(ks_q);
        end
    end

    // State register with synchronous reset to SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            ks_q <= SEED;
        end else begin
            ks_q <= ks_d;
        end
    end

    assign ks = ks_q;

endmodule

// File: rtl/vigenere_deciph.sv
// Streaming Vigenere decryptor: uppercase ciphertext in, lowercase plaintext
// out, one byte per cycle, key taken from an LFSR keystream.
//
// Handshake: a byte moves on an interface only in a cycle where its valid and
// ready are both high. s_ready is (!m_valid || m_ready) && !key_load && !rst,
// so the single output register refills in the same cycle it drains. While
// m_valid is high and m_ready low, m_valid/m_data/m_err do not change.
module vigenere_deciph
    import vig_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_err,
    input  logic        key_load,
    input  logic [31:0] key_seed,
    output logic [15:0] char_cnt
);

    logic [31:0] ks;
    logic [4:0]  key_k;
    logic        accept;
    logic        is_letter;
    logic        ks_step;

    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q,  m_data_d;
    logic        m_err_q,   m_err_d;
    logic [15:0] cnt_q,     cnt_d;

    // Keystream only advances on accepted letters; the key for a byte is the
    // state before that byte's step.
    vig_keystream #(
        .SEED (SEED)
    ) u_ks (
        .clk  (clk),
        .rst  (rst),
        .step (ks_step),
        .load (key_load),
        .seed (key_seed),
        .ks   (ks)
    );

    assign key_k     = key_of(ks[27:23]);
    assign is_letter = is_upper(s_data);
    assign s_ready   = (!m_valid_q || m_ready) && !key_load && !rst;
    assign accept    = s_valid && s_ready;
    assign ks_step   = accept && is_letter;

    // Output register and letter counter next state.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_err_d   = m_err_q;
        cnt_d     = cnt_q;
        if (accept) begin
            m_valid_d = 1'b1;
            if (is_letter) begin
                m_data_d = decipher(s_data, key_k);
                m_err_d  = 1'b0;
                cnt_d    = cnt_q + 16'd1;
            end else begin
                m_data_d = s_data;
                m_err_d  = 1'b1;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
        // A key load restarts the count; s_ready is low so nothing is accepted.
        if (key_load) begin
            cnt_d = 16'd0;
        end
    end

    // Registers; reset discards any pending output byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_err_q   <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_err_q   <= m_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_err    = m_err_q;
    assign char_cnt = cnt_q;

endmodule

// File: tb/tb_vigenere_deciph.sv
// Directed and random checks for vigenere_deciph.
module tb_vigenere_deciph;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_err;
    logic        key_load;
    logic [31:0] key_seed;
    logic [15:0] char_cnt;

    // clock / reset
    always #5 clk = ~clk;

    vigenere_deciph dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_err    (m_err),
        .key_load (key_load),
        .key_seed (key_seed),
        .char_cnt (char_cnt)
    );

    // reference model state and scoreboard
    logic [31:0] mdl_ks;
    logic [15:0] mdl_cnt;
    logic        mdl_mv = 1'b0;
    logic [8:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;

    typedef struct {
        logic [31:0] seed;
        logic [7:0]  din;
        logic [7:0]  exp_data;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    function automatic int ref_key(input logic [4:0] f);
        return int'(f) % 26;
    endfunction

    function automatic logic [7:0] ref_dec(input logic [7:0] c, input int k);
        int v;
        v = (int'(c) - 65 + 26 - k) % 26;
        return 8'(v + 97);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check s_ready and any handoff before the edge, update the
    // model at the edge, then check registered state just after it.
    task automatic cycle();
        logic       exp_rdy;
        logic       acc;
        logic [8:0] e;
        #1;
        exp_rdy = (!mdl_mv || m_ready) && !key_load && !rst;
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        acc = s_valid && exp_rdy;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_extra: got byte %h expected none at %0t", m_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(m_data), 32'(e[7:0]));
                chk("out_err", 32'(m_err), 32'(e[8]));
            end
        end
        @(posedge clk);
        if (rst) begin
            mdl_ks  = SEED;
            mdl_cnt = 16'd0;
            mdl_mv  = 1'b0;
            exp_q.delete();
        end else begin
            if (key_load) begin
                mdl_ks  = (key_seed == 32'h0) ? SEED : key_seed;
                mdl_cnt = 16'd0;
            end
            if (acc) begin
                n_acc++;
                if (s_data >= 8'h41 && s_data <= 8'h5A) begin
                    exp_q.push_back({1'b0, ref_dec(s_data, ref_key(mdl_ks[27:23]))});
                    mdl_ks  = ref_step(mdl_ks);
                    mdl_cnt = mdl_cnt + 16'd1;
                end else begin
                    exp_q.push_back({1'b1, s_data});
                end
                mdl_mv = 1'b1;
            end else if (m_ready) begin
                mdl_mv = 1'b0;
            end
        end
        #1;
        chk("m_valid", 32'(m_valid), 32'(mdl_mv));
        chk("char_cnt", 32'(char_cnt), 32'(mdl_cnt));
        chk("ks", dut.ks, mdl_ks);
    endtask

    // driver tasks
    task automatic idle();
        s_valid  = 1'b0;
        s_data   = 8'h00;
        key_load = 1'b0;
        key_seed = 32'h0;
        m_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_m_err", 32'(m_err), 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(s_ready), 32'h1);
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        cycle();
        s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        vecs[0]  = '{32'h0000_0001, 8'h41, 8'h61, 1'b0, 16'd1};
        vecs[1]  = '{32'h0000_0001, 8'h5A, 8'h7A, 1'b0, 16'd1};
        vecs[2]  = '{32'h0B80_0000, 8'h58, 8'h61, 1'b0, 16'd1};
        vecs[3]  = '{32'h0080_0000, 8'h41, 8'h7A, 1'b0, 16'd1};
        vecs[4]  = '{32'h0C80_0000, 8'h4D, 8'h6E, 1'b0, 16'd1};
        vecs[5]  = '{32'h0F80_0000, 8'h46, 8'h61, 1'b0, 16'd1};
        vecs[6]  = '{32'h0D00_0000, 8'h51, 8'h71, 1'b0, 16'd1};
        vecs[7]  = '{32'h0680_0000, 8'h41, 8'h6E, 1'b0, 16'd1};
        vecs[8]  = '{32'h0000_0001, 8'h40, 8'h40, 1'b1, 16'd0};
        vecs[9]  = '{32'h0000_0001, 8'h5B, 8'h5B, 1'b1, 16'd0};
        vecs[10] = '{32'h0000_0001, 8'h61, 8'h61, 1'b1, 16'd0};
        vecs[11] = '{32'h0000_0001, 8'hFF, 8'hFF, 1'b1, 16'd0};
        vecs[12] = '{32'h0000_0000, 8'h41, 8'h62, 1'b0, 16'd1};
        vecs[13] = '{32'h0A00_0000, 8'h43, 8'h69, 1'b0, 16'd1};

        rst = 1'b1;
        idle();
        cycle();
        do_reset();

        // First letter after reset uses k=25.
        send(8'h41);
        chk("first_A_data", 32'(m_data), 32'h62);
        chk("first_A_err", 32'(m_err), 32'h0);
        chk("first_A_cnt", 32'(char_cnt), 32'd1);

        // 'Z' then a space: the space passes through flagged, no step.
        do_reset();
        send(8'h5A);
        chk("Z_data", 32'(m_data), 32'h61);
        send(8'h20);
        chk("space_data", 32'(m_data), 32'h20);
        chk("space_err", 32'(m_err), 32'h1);
        chk("space_cnt", 32'(char_cnt), 32'd1);
        chk("space_ks", dut.ks, ref_step(SEED));
        cycle();

        // Table: load a seed, send one byte, check the recovered byte.
        for (int i = 0; i < 14; i++) begin
            idle();
            key_load = 1'b1;
            key_seed = vecs[i].seed;
            cycle();
            key_load = 1'b0;
            send(vecs[i].din);
            chk("vec_valid", 32'(m_valid), 32'h1);
            chk("vec_data", 32'(m_data), 32'(vecs[i].exp_data));
            chk("vec_err", 32'(m_err), 32'(vecs[i].exp_err));
            chk("vec_cnt", 32'(char_cnt), 32'(vecs[i].exp_cnt));
        end
        idle();
        cycle();

        // Source holds a byte through a key load; it goes in afterwards.
        key_load = 1'b1;
        key_seed = 32'h0B80_0000;
        s_valid  = 1'b1;
        s_data   = 8'h58;
        cycle();
        key_load = 1'b0;
        cycle();
        s_valid = 1'b0;
        chk("held_X_data", 32'(m_data), 32'h61);
        chk("held_X_cnt", 32'(char_cnt), 32'd1);
        cycle();

        // Backpressure: first byte held for 5 cycles while the source streams.
        do_reset();
        m_ready = 1'b0;
        send(8'h41);
        s_valid = 1'b1;
        s_data  = 8'h42;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", 32'(m_valid), 32'h1);
            chk("stall_data", 32'(m_data), 32'h62);
            chk("stall_ks", dut.ks, ref_step(SEED));
        end
        m_ready = 1'b1;
        cycle();
        s_data = 8'h43;
        cycle();
        s_data = 8'h2E;
        cycle();
        s_data = 8'h44;
        cycle();
        idle();
        cycle();
        cycle();
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with a pending byte and a source byte; reset beats key_load.
        m_ready = 1'b1;
        send(8'h41);
        m_ready  = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'h41;
        key_load = 1'b1;
        key_seed = 32'h1234_5678;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(m_valid), 32'h0);
        chk("rst_mid_cnt", 32'(char_cnt), 32'd0);
        chk("rst_mid_ks", dut.ks, SEED);
        idle();
        send(8'h41);
        chk("rst_resend_A", 32'(m_data), 32'h62);
        cycle();

        // Random stream of 1000 accepted bytes against the scoreboard.
        target = n_acc + 1000;
        for (int c = 0; c < 20000 && n_acc < target; c++) begin
            s_valid  = ($urandom_range(0, 9) < 7);
            s_data   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(65, 90));
            m_ready  = ($urandom_range(0, 3) != 0);
            key_load = ($urandom_range(0, 49) == 0);
            key_seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            cycle();
        end
        if (n_acc < target) begin
            n_vec++;
            n_err++;
            $display("FAIL rand_budget: got %0d accepts expected %0d", n_acc, target);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vigenere_deciph.md
VIGENERE_DECIPH -- requirements
Module: vigenere_deciph

Interface
REQ-001 Parameter: SEED, 32'hACE1_2468, default keystream state loaded at reset and on a zero key_seed load; SHALL be nonzero.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_valid  input  1  ciphertext byte valid.
REQ-005 s_ready  output  1  block accepts s_data this cycle.
REQ-006 s_data  input  8  ciphertext byte (ASCII).
REQ-007 m_valid  output  1  recovered byte valid.
REQ-008 m_ready  input  1  downstream accepts m_data this cycle.
REQ-009 m_data  output  8  recovered plaintext byte.
REQ-010 m_err  output  1  qualifies m_data: input byte was not uppercase A-Z.
REQ-011 key_load  input  1  load keystream state from key_seed.
REQ-012 key_seed  input  32  new keystream state.
REQ-013 char_cnt  output  16  count of letters decoded since reset or key load.

Function
REQ-014 Keystream state ks[31:0]; current key k = ks[27:23] mod 26 (range 0..25).
REQ-015 Step rule: ks <= {ks[30:0], ks[31]^ks[21]^ks[1]^ks[0]} (x^32+x^22+x^2+x+1); ks never steps except per REQ-018.
REQ-016 s_ready SHALL equal (!m_valid || m_ready) && !key_load && !rst.
REQ-017 Accept = s_valid && s_ready; m_data/m_err registered, latency exactly 1 cycle from accept to m_valid.
REQ-018 Accepted s_data in 8'h41..8'h5A: m_data = ((s_data-8'h41) + 26 - k) mod 26 + 8'h61; m_err=0; ks steps; char_cnt increments (wraps 16'hFFFF->0).
REQ-019 Accepted s_data outside 8'h41..8'h5A: m_data = s_data unchanged, m_err=1, ks and char_cnt unchanged.
REQ-020 Key used for a byte is the state before that byte's step; 9-bit or wider intermediates, no negative wrap.
REQ-021 While m_valid && !m_ready: m_data, m_err, m_valid held stable; no new accept.
REQ-022 Accept and m_ready in same cycle with m_valid=1: new byte replaces old, m_valid stays 1 (full throughput, one byte/cycle).
REQ-023 m_valid falls the cycle after m_ready with no new accept.
REQ-024 key_load=1: ks <= (key_seed==0) ? SEED : key_seed; char_cnt <= 0; no accept that cycle; pending output byte unaffected.
REQ-025 key_load has priority over any step; s_valid held by source is accepted after key_load deasserts.

Reset
REQ-026 On rst: ks=SEED, m_valid=0, m_data=8'h00, m_err=0, char_cnt=0, s_ready=0 that cycle.
REQ-027 rst mid-stream discards any pending output byte; rst overrides key_load.
REQ-028 First cycle after rst deasserts: s_ready=1.

Structure
REQ-029 Shared package vig_pkg SHALL hold ASCII bound constants (8'h41, 8'h5A, 8'h61), ALPHA_LEN=26, default SEED, and the LFSR tap constant.
REQ-030 Keystream register and step logic SHALL be sub-module vig_keystream (ports: clk, rst, step, load, seed, ks), reusable by a stepped encryptor.
REQ-031 Decryptor datapath and handshake stay in vigenere_deciph; no other sub-modules.

Verification
REQ-032 Reset, send 8'h41 ('A') with m_ready=1 -> next cycle m_valid=1, m_data=8'h62 ('b', k=25), m_err=0, char_cnt=1.
REQ-033 Reset, send 8'h5A ('Z') -> m_data=8'h61 ('a'); then 8'h20 -> m_data=8'h20, m_err=1, char_cnt stays 1, ks unchanged.
REQ-034 key_load with key_seed=32'h0B80_0000 (k=23), send 8'h58 ('X') -> m_data=8'h61, char_cnt=1; key_seed=0 load -> next letter uses SEED key.
REQ-035 m_ready=0 for 5 cycles with s_valid=1 streaming -> one byte held stable, s_ready=0, ks unchanged; release -> bytes delivered in order, no loss or duplication.
REQ-036 Assert rst while m_valid=1 and s_valid=1 -> next cycle m_valid=0, char_cnt=0, ks=SEED; re-sending 'A' yields 8'h62.
REQ-037 Random 1000-byte stream with random m_ready: scoreboard with a reference model using the same LFSR and mod-26 rule matches every byte and m_err.
